// File: rtl/rom_load_arbiter_if.sv
// Bus bundle for rom_load_arbiter: HPS download port, CPU read port and shared RAM port.
// The master modport is the arbiter; the slave modport is the surrounding system.
interface rom_load_arbiter_if #(
  parameter int unsigned ADDR_W = 16
);
  logic              ioctl_download;
  logic              ioctl_wr;
  logic [26:0]       ioctl_addr;
  logic [7:0]        ioctl_dout;
  logic              ioctl_wait;

  logic              cpu_req;
  logic [ADDR_W-1:0] cpu_addr;
  logic              cpu_ack;
  logic [7:0]        cpu_dout;

  logic [ADDR_W-1:0] mem_addr;
  logic [7:0]        mem_din;
  logic              mem_we;
  logic              mem_rd;
  logic [7:0]        mem_dout;

  logic              rom_ready;
  logic              core_rst;
  logic [7:0]        dl_sum;

  modport master (
    input  ioctl_download, ioctl_wr, ioctl_addr, ioctl_dout,
    input  cpu_req, cpu_addr, mem_dout,
    output ioctl_wait, cpu_ack, cpu_dout,
    output mem_addr, mem_din, mem_we, mem_rd,
    output rom_ready, core_rst, dl_sum
  );

  modport slave (
    output ioctl_download, ioctl_wr, ioctl_addr, ioctl_dout,
    output cpu_req, cpu_addr, mem_dout,
    input  ioctl_wait, cpu_ack, cpu_dout,
    input  mem_addr, mem_din, mem_we, mem_rd,
    input  rom_ready, core_rst, dl_sum
  );
endinterface

// File: rtl/rom_load_arbiter.sv
// Arbitrates a shared RAM between HPS ROM download writes and CPU reads.
// Optional download checksum on dl_sum is enabled by defining ROM_ARB_CHECKSUM_EN.
module rom_load_arbiter #(
  parameter int unsigned ADDR_W      = 16,
  parameter logic [26:0] REGION_BASE = 27'h0
) (
  input  logic           clk_sys,
  input  logic           reset,
  rom_load_arbiter_if.master bus
);

  typedef enum logic [1:0] {IDLE, WR, RD, ACK} state_t;

  state_t            state, state_nxt;
  logic              wbuf_valid;
  logic [ADDR_W-1:0] wbuf_addr;
  logic [7:0]        wbuf_data;
  logic              dl_prev;
  logic              dl_seen;
  logic              rom_ready_q;
  logic [27:0]       rel_addr;
  logic              in_range;
  logic              wbuf_load;
  logic              dl_rise;

  // Range check on the full-width offset, before truncation, so nothing aliases.
  assign rel_addr  = {1'b0, bus.ioctl_addr} - {1'b0, REGION_BASE};
  assign in_range  = (rel_addr >> ADDR_W) == '0;
  assign wbuf_load = bus.ioctl_wr && !wbuf_valid && in_range;
  assign dl_rise   = bus.ioctl_download && !dl_prev;

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (wbuf_valid)
          state_nxt = WR;
        else if (bus.cpu_req && !bus.ioctl_download && rom_ready_q)
          state_nxt = RD;
      end
      WR:      state_nxt = IDLE;
      RD:      state_nxt = ACK;
      ACK:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    bus.mem_we   = 1'b0;
    bus.mem_rd   = 1'b0;
    bus.cpu_ack  = 1'b0;
    bus.mem_addr = wbuf_addr;
    bus.mem_din  = wbuf_data;
    bus.cpu_dout = '0;
    case (state)
      WR:  bus.mem_we = 1'b1;
      RD: begin
        bus.mem_rd   = 1'b1;
        bus.mem_addr = bus.cpu_addr;
      end
      ACK: begin
        bus.cpu_ack  = 1'b1;
        bus.cpu_dout = bus.mem_dout;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      wbuf_valid <= 1'b0;
      wbuf_addr  <= '0;
      wbuf_data  <= '0;
    end else if (state == WR) begin
      wbuf_valid <= 1'b0;
    end else if (wbuf_load) begin
      wbuf_valid <= 1'b1;
      wbuf_addr  <= rel_addr[ADDR_W-1:0];
      wbuf_data  <= bus.ioctl_dout;
    end
  end

  // dl_seen marks that a download has happened since reset; ready waits for it to end and drain.
  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      dl_prev     <= 1'b0;
      dl_seen     <= 1'b0;
      rom_ready_q <= 1'b0;
    end else begin
      dl_prev <= bus.ioctl_download;
      dl_seen <= dl_seen | bus.ioctl_download;
      if (dl_rise)
        rom_ready_q <= 1'b0;
      else if (!bus.ioctl_download && dl_seen && !wbuf_valid && state == IDLE)
        rom_ready_q <= 1'b1;
    end
  end

`ifdef ROM_ARB_CHECKSUM_EN
  logic [7:0] sum_q;

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset)              sum_q <= '0;
    else if (dl_rise)       sum_q <= '0;
    else if (state == WR)   sum_q <= sum_q + wbuf_data;
  end

  assign bus.dl_sum = sum_q;
`else
  assign bus.dl_sum = '0;
`endif

  assign bus.ioctl_wait = wbuf_valid;
  assign bus.rom_ready  = rom_ready_q;
  assign bus.core_rst   = reset | ~rom_ready_q;

endmodule

// File: tb/tb_rom_load_arbiter.sv
// Scoreboard bench for rom_load_arbiter: random downloads and reads against a RAM reference model.
module tb_rom_load_arbiter;

  localparam int unsigned AW    = 8;
  localparam int unsigned DEPTH = 256;
  localparam int unsigned BASE  = 'h100;

  typedef struct {
    logic [AW-1:0] a;
    logic [7:0]    d;
  } wr_t;

  logic clk_sys;
  logic reset;

  rom_load_arbiter_if #(.ADDR_W(AW)) bus ();

  rom_load_arbiter #(
    .ADDR_W      (AW),
    .REGION_BASE (27'(BASE))
  ) dut (
    .clk_sys (clk_sys),
    .reset   (reset),
    .bus     (bus.master)
  );

  logic [7:0] ram     [DEPTH];
  logic [7:0] ref_mem [DEPTH];
  wr_t        wq[$];
  logic [7:0] rq[$];
  wr_t        w_exp;
  int         total;
  int         bad;
  bit         no_ack_window;
  logic [7:0] exp_sum;

  initial begin
    clk_sys = 1'b0;
    forever #5 clk_sys = ~clk_sys;
  end

  // Synchronous RAM: data appears the cycle after mem_rd.
  always @(posedge clk_sys) begin
    if (bus.mem_we) ram[bus.mem_addr] <= bus.mem_din;
    if (bus.mem_rd) bus.mem_dout <= ram[bus.mem_addr];
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic expire(input string name);
    total++;
    bad++;
    $display("FAIL %s: timed out at %0t", name, $time);
  endtask

  always @(negedge clk_sys) begin
    if (!reset) begin
      if (bus.mem_we) begin
        if (wq.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_write: got addr %0h data %0h want none", bus.mem_addr, bus.mem_din);
        end else begin
          w_exp = wq.pop_front();
          chk("wr_addr", 32'(bus.mem_addr), 32'(w_exp.a));
          chk("wr_data", 32'(bus.mem_din), 32'(w_exp.d));
        end
      end
      if (bus.cpu_ack) begin
        chk("ack_after_writes", 32'(wq.size()), 32'(0));
        if (rq.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_ack: got data %0h want no ack", bus.cpu_dout);
        end else begin
          chk("rd_data", 32'(bus.cpu_dout), 32'(rq.pop_front()));
        end
      end
      if (no_ack_window) chk("ack_gated", 32'(bus.cpu_ack), 32'(0));
    end
  end

  task automatic tick();
    @(posedge clk_sys);
    #1;
  endtask

  task automatic wr_byte(input int unsigned a, input logic [7:0] d, input bit chase);
    bit acc;
    acc = (a >= BASE) && (a < BASE + DEPTH);
    tick();
    bus.ioctl_wr   = 1'b1;
    bus.ioctl_addr = 27'(a);
    bus.ioctl_dout = d;
    if (acc) begin
      wq.push_back('{a: AW'(a - BASE), d: d});
      ref_mem[a - BASE] = d;
      exp_sum += d;
    end
    tick();
    if (chase) begin
      // A second strobe while the buffer is occupied must be dropped.
      bus.ioctl_addr = 27'(BASE + 3);
      bus.ioctl_dout = 8'h44;
      tick();
    end
    bus.ioctl_wr = 1'b0;
    @(negedge clk_sys);
    chk("ioctl_wait", 32'(bus.ioctl_wait), 32'(acc));
    for (int i = 0; i < 20 && bus.ioctl_wait; i++) @(negedge clk_sys);
    if (bus.ioctl_wait) expire("wait_drain");
  endtask

  task automatic rd(input int unsigned off);
    int  k;
    bit  got;
    tick();
    bus.cpu_req  = 1'b1;
    bus.cpu_addr = AW'(off);
    rq.push_back(ref_mem[off]);
    k   = 0;
    got = 1'b0;
    while (!got && k < 50) begin
      @(negedge clk_sys);
      k++;
      got = bus.cpu_ack;
    end
    if (!got) begin
      expire("rd_ack");
      rq.delete();
    end else begin
      chk("rd_latency", 32'(k - 1), 32'(2));
    end
    tick();
    bus.cpu_req = 1'b0;
  endtask

  task automatic dl_start();
    tick();
    bus.ioctl_download = 1'b1;
    exp_sum = 8'h00;
  endtask

  task automatic check_ready();
    for (int i = 0; i < 20 && !bus.rom_ready; i++) @(negedge clk_sys);
    chk("rom_ready", 32'(bus.rom_ready), 32'(1));
    chk("core_rst", 32'(bus.core_rst), 32'(0));
`ifdef ROM_ARB_CHECKSUM_EN
    chk("dl_sum", 32'(bus.dl_sum), 32'(exp_sum));
`else
    chk("dl_sum", 32'(bus.dl_sum), 32'(0));
`endif
  endtask

  task automatic dl_end();
    tick();
    bus.ioctl_download = 1'b0;
    @(negedge clk_sys);
    check_ready();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int unsigned a;
    total              = 0;
    bad                = 0;
    no_ack_window      = 1'b0;
    exp_sum            = 8'h00;
    for (int i = 0; i < int'(DEPTH); i++) begin
      ram[i]     = 8'h00;
      ref_mem[i] = 8'h00;
    end
    reset              = 1'b0;
    bus.ioctl_download = 1'b0;
    bus.ioctl_wr       = 1'b0;
    bus.ioctl_addr     = '0;
    bus.ioctl_dout     = '0;
    bus.cpu_req        = 1'b0;
    bus.cpu_addr       = '0;
    #2 reset = 1'b1;
    repeat (3) @(negedge clk_sys);
    chk("rst_wait", 32'(bus.ioctl_wait), 32'(0));
    chk("rst_mem_we", 32'(bus.mem_we), 32'(0));
    chk("rst_mem_rd", 32'(bus.mem_rd), 32'(0));
    chk("rst_cpu_ack", 32'(bus.cpu_ack), 32'(0));
    chk("rst_rom_ready", 32'(bus.rom_ready), 32'(0));
    chk("rst_core_rst", 32'(bus.core_rst), 32'(1));
    chk("rst_dl_sum", 32'(bus.dl_sum), 32'(0));
    tick();
    reset = 1'b0;
    repeat (4) @(negedge clk_sys);
    chk("no_dl_not_ready", 32'(bus.rom_ready), 32'(0));

    // Directed download including an ignored strobe and both out-of-range neighbours.
    dl_start();
    wr_byte(BASE + 0, 8'h11, 1'b1);
    wr_byte(BASE + 1, 8'h22, 1'b0);
    wr_byte(BASE + 2, 8'h33, 1'b0);
    wr_byte(BASE + DEPTH, 8'h99, 1'b0);
    wr_byte(BASE - 1, 8'h77, 1'b0);
    dl_end();
    rd(1);
    rd(3);
    rd(0);

    for (int r = 0; r < 3; r++) begin
      dl_start();
      for (int i = 0; i < 25; i++) begin
        a = BASE + $urandom_range(0, DEPTH + 19) - 10;
        wr_byte(a, 8'($urandom), 1'b0);
        repeat ($urandom_range(0, 2)) tick();
      end
      dl_end();
      for (int i = 0; i < 15; i++) rd($urandom_range(0, DEPTH - 1));
    end

    // Read held across a whole download must wait for it and see the final data.
    tick();
    bus.cpu_req        = 1'b1;
    bus.cpu_addr       = AW'(7);
    bus.ioctl_download = 1'b1;
    exp_sum            = 8'h00;
    no_ack_window      = 1'b1;
    @(negedge clk_sys);
    @(negedge clk_sys);
    chk("dl_clears_ready", 32'(bus.rom_ready), 32'(0));
    chk("dl_core_rst", 32'(bus.core_rst), 32'(1));
    for (int i = 0; i < 6; i++) begin
      a = (i == 3) ? BASE + 7 : BASE + $urandom_range(0, 15);
      wr_byte(a, 8'($urandom), 1'b0);
    end
    rq.push_back(ref_mem[7]);
    tick();
    bus.ioctl_download = 1'b0;
    no_ack_window      = 1'b0;
    begin
      bit got;
      got = 1'b0;
      for (int i = 0; i < 40 && !got; i++) begin
        @(negedge clk_sys);
        got = bus.cpu_ack;
      end
      if (!got) begin
        expire("held_rd_ack");
        rq.delete();
      end
    end
    tick();
    bus.cpu_req = 1'b0;
    @(negedge clk_sys);
    check_ready();

    // Reset while a byte sits in the buffer: that byte must never reach RAM.
    dl_start();
    tick();
    bus.ioctl_wr   = 1'b1;
    bus.ioctl_addr = 27'(BASE + 5);
    bus.ioctl_dout = 8'hA5;
    tick();
    bus.ioctl_wr = 1'b0;
    reset        = 1'b1;
    @(negedge clk_sys);
    chk("midrst_wait", 32'(bus.ioctl_wait), 32'(0));
    chk("midrst_mem_we", 32'(bus.mem_we), 32'(0));
    chk("midrst_rom_ready", 32'(bus.rom_ready), 32'(0));
    chk("midrst_core_rst", 32'(bus.core_rst), 32'(1));
    chk("midrst_dl_sum", 32'(bus.dl_sum), 32'(0));
    bus.ioctl_download = 1'b0;
    repeat (2) tick();
    reset = 1'b0;
    repeat (5) @(negedge clk_sys);
    chk("post_rst_not_ready", 32'(bus.rom_ready), 32'(0));
    chk("post_rst_core_rst", 32'(bus.core_rst), 32'(1));
    dl_start();
    wr_byte(BASE + 9, 8'h3C, 1'b0);
    dl_end();
    rd(5);
    rd(9);

    repeat (4) @(negedge clk_sys);
    chk("wq_drained", 32'(wq.size()), 32'(0));
    chk("rq_drained", 32'(rq.size()), 32'(0));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
